target_box_locator: RTL and testbench

//  Per-frame bounding-box extractor for the Recognize path. Consumes a binarised

---
 rtl/target_box_locator.sv | 129 ++++++++++++
 tb/tb_target_box_locator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/target_box_locator.sv
// Per-frame bounding-box extractor: tracks min/max column/row of target pixels and
// publishes an exclusive-bound, margin-expanded, clamped box once per frame.
module target_box_locator #(
  parameter logic        VS_ACTIVE = 1'b1,
  parameter logic [11:0] MARGIN    = 12'd4,
  parameter logic [15:0] MIN_PIX   = 16'd64,
  parameter logic [11:0] H_MAX     = 12'd1279,
  parameter logic [11:0] V_MAX     = 12'd719
) (
  input  logic        pixelclk,
  input  logic        reset_n,
  input  logic        i_bin,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_de,
  input  logic [11:0] hcount,
  input  logic [11:0] vcount,
  output logic [11:0] hcount_l,
  output logic [11:0] hcount_r,
  output logic [11:0] vcount_l,
  output logic [11:0] vcount_r,
  output logic        o_box_valid,
  output logic        o_frame_done,
  output logic [15:0] o_pix_count
);

  typedef enum logic [1:0] {SYNC, ACCUM, PUBLISH} state_t;

  state_t      state;
  logic        vs_d;
  logic [11:0] xmin, xmax, ymin, ymax;
  logic [15:0] count;
  logic        fe;
  logic        hit;
  logic        unused_hsync;

  assign unused_hsync = i_hsync;
  assign fe  = (i_vsync == VS_ACTIVE) && (vs_d != VS_ACTIVE);
  assign hit = i_de && i_bin;

  // Lower exclusive bound: min - 1 - MARGIN, floored at 0 instead of wrapping.
  function automatic logic [11:0] lo_bound(input logic [11:0] mn);
    logic [12:0] diff;
    diff = {1'b0, mn} - {1'b0, MARGIN} - 13'd1;
    return (mn > MARGIN) ? diff[11:0] : 12'd0;
  endfunction

  // Upper exclusive bound: max + 1 + MARGIN, capped at one past the last legal index.
  function automatic logic [11:0] hi_bound(input logic [11:0] mx, input logic [11:0] lim_max);
    logic [12:0] sum;
    logic [12:0] lim;
    sum = {1'b0, mx} + {1'b0, MARGIN} + 13'd1;
    lim = {1'b0, lim_max} + 13'd1;
    return (sum > lim) ? lim[11:0] : sum[11:0];
  endfunction

  // NOTE: all state here is sequential, so every assignment uses <= to avoid
  // read-before-write races between blocks sharing the same clock edge.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= SYNC;
      vs_d         <= VS_ACTIVE;
      xmin         <= 12'hFFF;
      ymin         <= 12'hFFF;
      xmax         <= 12'd0;
      ymax         <= 12'd0;
      count        <= 16'd0;
      hcount_l     <= 12'd0;
      hcount_r     <= 12'd0;
      vcount_l     <= 12'd0;
      vcount_r     <= 12'd0;
      o_box_valid  <= 1'b0;
      o_frame_done <= 1'b0;
      o_pix_count  <= 16'd0;
    end else begin
      vs_d         <= i_vsync;
      o_frame_done <= 1'b0;
      case (state)
        SYNC: begin
          if (fe) begin
            state <= ACCUM;
            xmin  <= 12'hFFF;
            ymin  <= 12'hFFF;
            xmax  <= 12'd0;
            ymax  <= 12'd0;
            count <= 16'd0;
          end
        end
        ACCUM: begin
          if (fe) begin
            state <= PUBLISH;
          end else if (hit) begin
            if (hcount < xmin) xmin <= hcount;
            if (hcount > xmax) xmax <= hcount;
            if (vcount < ymin) ymin <= vcount;
            if (vcount > ymax) ymax <= vcount;
            if (count != 16'hFFFF) count <= count + 16'd1;
          end
        end
        PUBLISH: begin
          // A sparse frame publishes an empty window so the crop stage shows black.
          if (count >= MIN_PIX) begin
            hcount_l    <= lo_bound(xmin);
            hcount_r    <= hi_bound(xmax, H_MAX);
            vcount_l    <= lo_bound(ymin);
            vcount_r    <= hi_bound(ymax, V_MAX);
            o_box_valid <= 1'b1;
          end else begin
            hcount_l    <= 12'd0;
            hcount_r    <= 12'd0;
            vcount_l    <= 12'd0;
            vcount_r    <= 12'd0;
            o_box_valid <= 1'b0;
          end
          o_pix_count  <= count;
          o_frame_done <= 1'b1;
          xmin         <= 12'hFFF;
          ymin         <= 12'hFFF;
          xmax         <= 12'd0;
          ymax         <= 12'd0;
          count        <= 16'd0;
          state        <= ACCUM;
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_target_box_locator.sv
// Bench for target_box_locator: sparse pixel streams per frame, a queue-based
// reference model of the box, and every-cycle output comparison.
module tb_target_box_locator;

  logic        pixelclk = 1'b0;
  logic        reset_n;
  logic        i_bin, i_hsync, i_vsync, i_de;
  logic [11:0] hcount, vcount;
  logic [11:0] hcount_l, hcount_r, vcount_l, vcount_r;
  logic        o_box_valid, o_frame_done;
  logic [15:0] o_pix_count;

  always #5 pixelclk = ~pixelclk;

  target_box_locator dut (
    .pixelclk     (pixelclk),
    .reset_n      (reset_n),
    .i_bin        (i_bin),
    .i_hsync      (i_hsync),
    .i_vsync      (i_vsync),
    .i_de         (i_de),
    .hcount       (hcount),
    .vcount       (vcount),
    .hcount_l     (hcount_l),
    .hcount_r     (hcount_r),
    .vcount_l     (vcount_l),
    .vcount_r     (vcount_r),
    .o_box_valid  (o_box_valid),
    .o_frame_done (o_frame_done),
    .o_pix_count  (o_pix_count)
  );

  typedef struct {int h; int v;} px_t;

  px_t frame_q[$];
  bit  synced;
  int  e_l, e_r, e_vl, e_vr, e_valid, e_cnt;
  bit  e_done;
  int  passed = 0;
  int  fails  = 0;
  int  total  = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] outs_now();
    return {15'd0, hcount_l, hcount_r, vcount_l, vcount_r, o_box_valid, o_pix_count};
  endfunction

  function automatic logic [79:0] outs_exp();
    return {15'd0, 12'(e_l), 12'(e_r), 12'(e_vl), 12'(e_vr), 1'(e_valid), 16'(e_cnt)};
  endfunction

  function automatic void model_clear_outputs();
    e_l = 0; e_r = 0; e_vl = 0; e_vr = 0; e_valid = 0; e_cnt = 0;
  endfunction

  // Reference box: plain min/max over the frame's recorded target pixels.
  function automatic void model_publish();
    int n, xmin, xmax, ymin, ymax;
    n = frame_q.size();
    e_cnt = (n > 65535) ? 65535 : n;
    if (e_cnt < 64) begin
      e_l = 0; e_r = 0; e_vl = 0; e_vr = 0; e_valid = 0;
    end else begin
      xmin = 4095; ymin = 4095; xmax = 0; ymax = 0;
      foreach (frame_q[i]) begin
        if (frame_q[i].h < xmin) xmin = frame_q[i].h;
        if (frame_q[i].h > xmax) xmax = frame_q[i].h;
        if (frame_q[i].v < ymin) ymin = frame_q[i].v;
        if (frame_q[i].v > ymax) ymax = frame_q[i].v;
      end
      e_l  = (xmin - 5 < 0) ? 0 : xmin - 5;
      e_vl = (ymin - 5 < 0) ? 0 : ymin - 5;
      e_r  = (xmax + 5 > 1280) ? 1280 : xmax + 5;
      e_vr = (ymax + 5 > 720) ? 720 : ymax + 5;
      e_valid = 1;
    end
  endfunction

  task automatic tick(input string tag);
    @(posedge pixelclk);
    #1;
    check({tag, "_outs"}, outs_now(), outs_exp());
    check({tag, "_done"}, {79'd0, o_frame_done}, {79'd0, e_done});
  endtask

  task automatic drive(input int h, input int v, input bit de, input bit bin);
    hcount  = 12'(h);
    vcount  = 12'(v);
    i_de    = de;
    i_bin   = bin;
    i_hsync = (h == 0);
    tick("px");
    if (de && bin) frame_q.push_back('{h, v});
  endtask

  // Vsync pulse; optionally a target pixel rides along in the fe cycle and must be dropped.
  task automatic end_frame(input bit fe_pix);
    i_vsync = 1'b1;
    i_de    = fe_pix;
    i_bin   = fe_pix;
    hcount  = 12'd1000;
    vcount  = 12'd700;
    e_done  = 1'b0;
    tick("fe");
    i_de  = 1'b0;
    i_bin = 1'b0;
    if (synced) begin
      model_publish();
      e_done = 1'b1;
    end else begin
      synced = 1'b1;
    end
    frame_q.delete();
    tick("publish");
    e_done = 1'b0;
    repeat (6) tick("vs_hold");
    i_vsync = 1'b0;
    repeat (4) tick("vs_low");
  endtask

  task automatic rand_frame(input int n_hit, input int h0, input int h1, input int v0, input int v1);
    int got;
    got = 0;
    while (got < n_hit) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          drive($urandom_range(h0, h1), $urandom_range(v0, v1), 1'b1, 1'b1);
          got++;
        end
        2: drive($urandom_range(0, 1279), $urandom_range(0, 719), 1'b1, 1'b0);
        default: drive($urandom_range(0, 1279), $urandom_range(0, 719), 1'b0, 1'b1);
      endcase
    end
  endtask

  task automatic square_frame();
    for (int r = 200; r < 210; r++) begin
      drive(50, r, 1'b1, 1'b0);
      for (int c = 100; c < 110; c++) drive(c, r, 1'b1, 1'b1);
      drive(900, r, 1'b0, 1'b1);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    i_bin = 1'b0; i_hsync = 1'b0; i_vsync = 1'b0; i_de = 1'b0;
    hcount = '0; vcount = '0;
    synced = 1'b0;
    e_done = 1'b0;
    model_clear_outputs();

    // Reset state
    repeat (3) @(posedge pixelclk);
    #1;
    check("reset_outs", outs_now(), 80'd0);
    check("reset_done", {79'd0, o_frame_done}, 80'd0);
    #2 reset_n = 1'b1;
    repeat (2) tick("idle");

    // Square target: first fe only syncs, second fe publishes
    square_frame();
    end_frame(1'b0);
    check("sync_no_publish", outs_now(), 80'd0);
    square_frame();
    end_frame(1'b0);
    check("sq_l",     {68'd0, hcount_l}, 80'd95);
    check("sq_r",     {68'd0, hcount_r}, 80'd114);
    check("sq_vl",    {68'd0, vcount_l}, 80'd195);
    check("sq_vr",    {68'd0, vcount_r}, 80'd214);
    check("sq_valid", {79'd0, o_box_valid}, 80'd1);
    check("sq_count", {64'd0, o_pix_count}, 80'd100);

    // 63 targets: below threshold gives an empty window
    rand_frame(63, 400, 800, 100, 600);
    end_frame(1'b0);
    check("sparse_valid", {79'd0, o_box_valid}, 80'd0);
    check("sparse_bounds", {32'd0, hcount_l, hcount_r, vcount_l, vcount_r}, 80'd0);
    check("sparse_count", {64'd0, o_pix_count}, 80'd63);

    // Raster corners: clamping at both ends, no wrap
    drive(0, 0, 1'b1, 1'b1);
    drive(1279, 719, 1'b1, 1'b1);
    rand_frame(62, 0, 1279, 0, 719);
    end_frame(1'b0);
    check("edge_l",  {68'd0, hcount_l}, 80'd0);
    check("edge_vl", {68'd0, vcount_l}, 80'd0);
    check("edge_r",  {68'd0, hcount_r}, 80'd1280);
    check("edge_vr", {68'd0, vcount_r}, 80'd720);

    // Target with de=0 and a target in the fe cycle are both ignored
    rand_frame(35, 300, 400, 300, 400);
    drive(5, 5, 1'b0, 1'b1);
    rand_frame(35, 300, 400, 300, 400);
    end_frame(1'b1);
    check("ign_count", {64'd0, o_pix_count}, 80'd70);
    check("ign_r_inside", {79'd0, hcount_r <= 12'd405}, 80'd1);
    check("ign_l_inside", {79'd0, hcount_l >= 12'd295}, 80'd1);

    // Async reset mid-frame
    rand_frame(40, 600, 700, 100, 200);
    @(posedge pixelclk);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_outs", outs_now(), 80'd0);
    check("midrst_done", {79'd0, o_frame_done}, 80'd0);
    model_clear_outputs();
    synced = 1'b0;
    frame_q.delete();
    repeat (2) tick("in_reset");
    #2 reset_n = 1'b1;
    rand_frame(80, 600, 700, 100, 200);
    end_frame(1'b0);
    check("post_rst_sync", outs_now(), 80'd0);
    rand_frame(90, 10, 1270, 10, 710);
    end_frame(1'b0);
    check("post_rst_valid", {79'd0, o_box_valid}, 80'd1);

    // Further random frames, outputs compared every cycle
    for (int f = 0; f < 3; f++) begin
      rand_frame($urandom_range(50, 150), 0, $urandom_range(0, 1279), 0, $urandom_range(0, 719));
      end_frame(1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
